counter_b32_mode: RTL and testbench

- Synthesizable 32-bit mode-selectable counter: count up, count down, count down by 3, parallel load.
- It is the device driven by the counter tester bench. That bench supplies stimulus and compares the behavioural and synthesized netlists against this block.
- Registered outputs Q, rco and load; all updates occur on a single clock edge.

---
 rtl/counter_b32_mode_if.sv | 39 +++
 rtl/counter_b32_mode.sv | 88 ++++++++
 tb/tb_counter_b32_mode.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/counter_b32_mode_if.sv
// ---------------------------------------------------------------------------
// counter_b32_mode_if
// Bundles the control, data and status signals of the 32-bit mode counter.
//   b32_enable : count/load qualifier       (master -> slave)
//   b32_mode   : 00 up, 01 down, 10 down-by-step, 11 load (master -> slave)
//   b32_D      : parallel load value        (master -> slave)
//   b32_Q      : registered counter value   (slave -> master)
//   b32_rco    : registered wrap/borrow pulse (slave -> master)
//   b32_load   : registered load-done pulse (slave -> master)
// The master modport is the stimulus side and the slave modport is the counter.
// ---------------------------------------------------------------------------
interface counter_b32_mode_if #(
    parameter int WIDTH = 32
);
    logic             b32_enable;
    logic [1:0]       b32_mode;
    logic [WIDTH-1:0] b32_D;
    logic [WIDTH-1:0] b32_Q;
    logic             b32_rco;
    logic             b32_load;

    modport master (
        output b32_enable,
        output b32_mode,
        output b32_D,
        input  b32_Q,
        input  b32_rco,
        input  b32_load
    );

    modport slave (
        input  b32_enable,
        input  b32_mode,
        input  b32_D,
        output b32_Q,
        output b32_rco,
        output b32_load
    );
endinterface

// File: rtl/counter_b32_mode.sv
// ---------------------------------------------------------------------------
// counter_b32_mode
// Mode-selectable WIDTH-bit counter: up, down, down by DOWN_STEP, parallel load.
// Ports:
//   b32_clk   : single clock, rising edge
//   b32_reset : synchronous active-high reset (clears Q, rco, load)
//   bus       : counter_b32_mode_if.slave (enable, mode, D in; Q, rco, load out)
// All outputs come straight from registers; one cycle of latency.
// Optional build macro COUNTER_B32_SAT_EN: counting modes clamp at the range
// limits instead of wrapping, with rco held high while the clamp is active.
// ---------------------------------------------------------------------------
module counter_b32_mode #(
    parameter int WIDTH     = 32,
    parameter int DOWN_STEP = 3
) (
    input  logic                b32_clk,
    input  logic                b32_reset,
    counter_b32_mode_if.slave   bus
);
    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_DOWN3 = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(DOWN_STEP);

    logic [WIDTH-1:0] q_reg, q_next;
    logic             rco_reg, rco_next;
    logic             load_reg, load_next;
    // One extra bit on top catches carry (up) or borrow (down) from the
    // zero-extended operand.
    logic [WIDTH:0]   sum_ext;

    always_comb begin
        q_next    = q_reg;
        rco_next  = 1'b0;
        load_next = 1'b0;
        sum_ext   = {1'b0, q_reg};

        if (bus.b32_enable) begin
            case (bus.b32_mode)
                MODE_UP: begin
                    sum_ext  = {1'b0, q_reg} + ONE_EXT;
                    rco_next = sum_ext[WIDTH];
`ifdef COUNTER_B32_SAT_EN
                    q_next   = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
`else
                    q_next   = sum_ext[WIDTH-1:0];
`endif
                end
                MODE_DOWN, MODE_DOWN3: begin
                    sum_ext  = {1'b0, q_reg} -
                               ((bus.b32_mode == MODE_DOWN) ? ONE_EXT : STEP_EXT);
                    rco_next = sum_ext[WIDTH];
`ifdef COUNTER_B32_SAT_EN
                    q_next   = sum_ext[WIDTH] ? {WIDTH{1'b0}} : sum_ext[WIDTH-1:0];
`else
                    q_next   = sum_ext[WIDTH-1:0];
`endif
                end
                MODE_LOAD: begin
                    q_next    = bus.b32_D;
                    load_next = 1'b1;
                end
                default: begin
                    q_next = q_reg;
                end
            endcase
        end
    end

    always_ff @(posedge b32_clk) begin
        if (b32_reset) begin
            q_reg    <= '0;
            rco_reg  <= 1'b0;
            load_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            rco_reg  <= rco_next;
            load_reg <= load_next;
        end
    end

    assign bus.b32_Q    = q_reg;
    assign bus.b32_rco  = rco_reg;
    assign bus.b32_load = load_reg;
endmodule

// File: tb/tb_counter_b32_mode.sv
// ---------------------------------------------------------------------------
// tb_counter_b32_mode
// Directed plus randomized stimulus for counter_b32_mode, checked each cycle
// against an arithmetic reference model of the counter rules.
// ---------------------------------------------------------------------------
module tb_counter_b32_mode;
    localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;
    localparam longint unsigned STEP = 3;

    logic b32_clk   = 1'b0;
    logic b32_reset = 1'b1;

    counter_b32_mode_if #(.WIDTH(32)) bus ();

    counter_b32_mode #(.WIDTH(32), .DOWN_STEP(3)) dut (
        .b32_clk   (b32_clk),
        .b32_reset (b32_reset),
        .bus       (bus)
    );

    always #5 b32_clk = ~b32_clk;

    int checks = 0;
    int errors = 0;

    longint unsigned m_q    = 0;
    logic            m_rco  = 1'b0;
    logic            m_load = 1'b0;

    // Reference model: applies the counter rules with plain integer arithmetic.
    task automatic model_step(input logic rst, input logic en,
                              input logic [1:0] md, input logic [31:0] d);
        bit sat;
`ifdef COUNTER_B32_SAT_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        m_rco  = 1'b0;
        m_load = 1'b0;
        if (rst) begin
            m_q = 0;
        end else if (en) begin
            case (md)
                2'd0: if (m_q == MAXV) begin
                          m_rco = 1'b1;
                          m_q   = sat ? MAXV : 0;
                      end else m_q = m_q + 1;
                2'd1: if (m_q == 0) begin
                          m_rco = 1'b1;
                          m_q   = sat ? 0 : MAXV;
                      end else m_q = m_q - 1;
                2'd2: if (m_q < STEP) begin
                          m_rco = 1'b1;
                          m_q   = sat ? 0 : m_q + (MAXV + 1) - STEP;
                      end else m_q = m_q - STEP;
                default: begin
                    m_q    = longint'(d);
                    m_load = 1'b1;
                end
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (bus.b32_Q === m_q[31:0]) else begin
            errors++;
            $error("FAIL %s Q got %h expected %h", tag, bus.b32_Q, m_q[31:0]);
        end
        checks++;
        assert (bus.b32_rco === m_rco) else begin
            errors++;
            $error("FAIL %s rco got %b expected %b", tag, bus.b32_rco, m_rco);
        end
        checks++;
        assert (bus.b32_load === m_load) else begin
            errors++;
            $error("FAIL %s load got %b expected %b", tag, bus.b32_load, m_load);
        end
        checks++;
        assert (!(bus.b32_rco === 1'b1 && bus.b32_load === 1'b1)) else begin
            errors++;
            $error("FAIL %s rco_and_load both high got rco=%b load=%b expected not both",
                   tag, bus.b32_rco, bus.b32_load);
        end
    endtask

    // One clock transaction: drive, clock, advance model, sample 1 time unit later.
    task automatic cycle(input logic rst, input logic en, input logic [1:0] md,
                         input logic [31:0] d, input string tag);
        b32_reset      = rst;
        bus.b32_enable = en;
        bus.b32_mode   = md;
        bus.b32_D      = d;
        @(posedge b32_clk);
        model_step(rst, en, md, d);
        #1;
        $display("%-10s rst=%b en=%b mode=%0d D=%h -> Q=%h rco=%b load=%b",
                 tag, rst, en, md, d, bus.b32_Q, bus.b32_rco, bus.b32_load);
        check_outputs(tag);
    endtask

    // Build-independent fixed expectations from the directed plan.
    task automatic expect_q(input string tag, input logic [31:0] exp_q);
        checks++;
        assert (bus.b32_Q === exp_q) else begin
            errors++;
            $error("FAIL %s fixed Q got %h expected %h", tag, bus.b32_Q, exp_q);
        end
    endtask

    initial begin
        logic [31:0] d_r;
        logic [31:0] seq [6];

        bus.b32_enable = 1'b1;
        bus.b32_mode   = 2'b00;
        bus.b32_D      = 32'hA;

        // Reset held with counting requested.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 2'b00, 32'hA, "rst_hold");
            expect_q("rst_hold", 32'h0);
        end
        cycle(1'b0, 1'b1, 2'b00, 32'hA, "rst_exit");
        expect_q("rst_exit", 32'h1);

        // Up-count across the top boundary.
        cycle(1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, "ld_max");
        expect_q("ld_max", 32'hFFFF_FFFF);
        cycle(1'b0, 1'b1, 2'b00, 32'h0, "up_wrap");
        cycle(1'b0, 1'b1, 2'b00, 32'h0, "up_after");

        // Down-by-3 borrow.
        cycle(1'b0, 1'b1, 2'b11, 32'h2, "ld_2");
        expect_q("ld_2", 32'h2);
        cycle(1'b0, 1'b1, 2'b10, 32'h0, "dn3_wrap");
        cycle(1'b0, 1'b1, 2'b10, 32'h0, "dn3_after");
        cycle(1'b0, 1'b1, 2'b11, 32'h1, "ld_1b");
        cycle(1'b0, 1'b1, 2'b10, 32'h0, "dn3_from1");

        // Down-by-1 across zero.
        cycle(1'b0, 1'b1, 2'b11, 32'h1, "ld_1");
        cycle(1'b0, 1'b1, 2'b01, 32'h0, "dn_to0");
        cycle(1'b0, 1'b1, 2'b01, 32'h0, "dn_wrap");
        cycle(1'b0, 1'b1, 2'b01, 32'h0, "dn_clamp");

        // Hold with enable low.
        cycle(1'b0, 1'b1, 2'b11, 32'hB, "ld_B");
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 2'(i), 32'h1234_5678, "hold");
            expect_q("hold", 32'hB);
        end
        cycle(1'b0, 1'b1, 2'b00, 32'h0, "hold_exit");
        expect_q("hold_exit", 32'hC);

        // Consecutive loads, reset in the middle.
        seq[0] = 32'h1; seq[1] = 32'h2; seq[2] = 32'hA;
        seq[3] = 32'hB; seq[4] = 32'hE; seq[5] = 32'hF;
        for (int i = 0; i < 6; i++) begin
            cycle((i == 3) ? 1'b1 : 1'b0, 1'b1, 2'b11, seq[i], "ld_seq");
            expect_q("ld_seq", (i == 3) ? 32'h0 : seq[i]);
        end

        // Randomized traffic, loads biased toward the range limits.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: d_r = 32'h0;
                1: d_r = 32'h1;
                2: d_r = 32'h2;
                3: d_r = 32'hFFFF_FFFF;
                4: d_r = 32'hFFFF_FFFE;
                default: d_r = $urandom;
            endcase
            cycle(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)), d_r, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
